// File: rtl/conv_layer_sequencer_if.sv
// Controller / pixel-source side of the layer sequencer: launch handshake,
// per-group parameters and the frame-replay handshake.
interface conv_layer_sequencer_if #(
    parameter int WT_ADDR_WIDTH   = 12,
    parameter int BIAS_ADDR_WIDTH = 7
);
    logic [9:0]                 conv_ci_groups;
    logic [BIAS_ADDR_WIDTH-1:0] conv_output_group;
    logic [WT_ADDR_WIDTH-1:0]   conv_wt_base_addr;
    logic                       conv_go;
    logic                       conv_busy;
    logic                       conv_done;
    logic                       stream_restart;
    logic                       stream_ready;

    modport master (
        output conv_ci_groups,
        output conv_output_group,
        output conv_wt_base_addr,
        output conv_go,
        output stream_restart,
        input  conv_busy,
        input  conv_done,
        input  stream_ready
    );

    modport slave (
        input  conv_ci_groups,
        input  conv_output_group,
        input  conv_wt_base_addr,
        input  conv_go,
        input  stream_restart,
        output conv_busy,
        output conv_done,
        output stream_ready
    );
endinterface

// File: rtl/conv_layer_sequencer.sv
// Layer scheduler: launches the convolution controller once per output-channel
// group, replaying the pixel stream before each launch.
module conv_layer_sequencer #(
    parameter int WT_ADDR_WIDTH   = 12,
    parameter int BIAS_ADDR_WIDTH = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [BIAS_ADDR_WIDTH:0]   cfg_co_groups,
    input  logic [9:0]                 cfg_ci_groups,
    input  logic [WT_ADDR_WIDTH-1:0]   cfg_wt_layer_base,
    input  logic                       start,
    input  logic                       abort,
    output logic                       busy,
    output logic                       layer_done,
    output logic                       err_cfg,
    output logic                       aborted,
    output logic [BIAS_ADDR_WIDTH-1:0] group_idx,
    conv_layer_sequencer_if.master     ctrl
);

    localparam int CO_W  = BIAS_ADDR_WIDTH + 1;
    localparam int SUM_W = (WT_ADDR_WIDTH >= 10) ? WT_ADDR_WIDTH + 1 : 11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT_STREAM,
        S_WAIT_DONE
    } state_t;

    state_t                     r_state;
    logic [CO_W-1:0]            r_co;
    logic [9:0]                 r_ci;
    logic [WT_ADDR_WIDTH-1:0]   r_addr;
    logic [BIAS_ADDR_WIDTH-1:0] r_g;

    logic                       r_busy;
    logic                       r_layer_done;
    logic                       r_err_cfg;
    logic                       r_aborted;
    logic [BIAS_ADDR_WIDTH-1:0] r_group_idx;
    logic [9:0]                 r_conv_ci;
    logic [BIAS_ADDR_WIDTH-1:0] r_conv_group;
    logic [WT_ADDR_WIDTH-1:0]   r_conv_addr;
    logic                       r_conv_go;
    logic                       r_stream_restart;

    logic [SUM_W-1:0]           w_next_sum;
    logic                       w_wrap;
    logic                       w_last;
    logic                       w_cfg_bad;
    logic                       w_launch_ok;

    // Any bit above the address width means the next group's weights wrapped.
    assign w_next_sum  = SUM_W'(r_addr) + SUM_W'(r_ci);
    assign w_wrap      = |w_next_sum[SUM_W-1:WT_ADDR_WIDTH];
    assign w_last      = (CO_W'(r_g) + CO_W'(1)) == r_co;
    assign w_cfg_bad   = (cfg_co_groups == '0) || (cfg_ci_groups == '0);
    // A ready seen alongside our own restart pulse predates the rewind.
    assign w_launch_ok = !r_stream_restart && ctrl.stream_ready && !ctrl.conv_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_co             <= '0;
            r_ci             <= '0;
            r_addr           <= '0;
            r_g              <= '0;
            r_busy           <= 1'b0;
            r_layer_done     <= 1'b0;
            r_err_cfg        <= 1'b0;
            r_aborted        <= 1'b0;
            r_group_idx      <= '0;
            r_conv_ci        <= '0;
            r_conv_group     <= '0;
            r_conv_addr      <= '0;
            r_conv_go        <= 1'b0;
            r_stream_restart <= 1'b0;
        end else begin
            r_layer_done     <= 1'b0;
            r_err_cfg        <= 1'b0;
            r_aborted        <= 1'b0;
            r_conv_go        <= 1'b0;
            r_stream_restart <= 1'b0;

            if (r_state != S_IDLE && abort) begin
                r_state   <= S_IDLE;
                r_busy    <= 1'b0;
                r_aborted <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            if (w_cfg_bad) begin
                                r_err_cfg <= 1'b1;
                            end else begin
                                r_co    <= cfg_co_groups;
                                r_ci    <= cfg_ci_groups;
                                r_addr  <= cfg_wt_layer_base;
                                r_g     <= '0;
                                r_busy  <= 1'b1;
                                r_state <= S_SETUP;
                            end
                        end
                    end

                    S_SETUP: begin
                        r_conv_group     <= r_g;
                        r_group_idx      <= r_g;
                        r_conv_addr      <= r_addr;
                        r_conv_ci        <= r_ci;
                        r_stream_restart <= 1'b1;
                        r_state          <= S_WAIT_STREAM;
                    end

                    S_WAIT_STREAM: begin
                        if (w_launch_ok) begin
                            r_conv_go <= 1'b1;
                            r_state   <= S_WAIT_DONE;
                        end
                    end

                    S_WAIT_DONE: begin
                        if (ctrl.conv_done) begin
                            if (w_last) begin
                                r_busy       <= 1'b0;
                                r_layer_done <= 1'b1;
                                r_state      <= S_IDLE;
                            end else if (w_wrap) begin
                                r_busy    <= 1'b0;
                                r_err_cfg <= 1'b1;
                                r_state   <= S_IDLE;
                            end else begin
                                r_g     <= r_g + BIAS_ADDR_WIDTH'(1);
                                r_addr  <= w_next_sum[WT_ADDR_WIDTH-1:0];
                                r_state <= S_SETUP;
                            end
                        end
                    end

                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign busy                   = r_busy;
    assign layer_done             = r_layer_done;
    assign err_cfg                = r_err_cfg;
    assign aborted                = r_aborted;
    assign group_idx              = r_group_idx;
    assign ctrl.conv_ci_groups    = r_conv_ci;
    assign ctrl.conv_output_group = r_conv_group;
    assign ctrl.conv_wt_base_addr = r_conv_addr;
    assign ctrl.conv_go           = r_conv_go;
    assign ctrl.stream_restart    = r_stream_restart;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Bench for conv_layer_sequencer: layer-level reference model compared every
// cycle, plus directed scenarios with hand-computed launch values and timing.
module tb_conv_layer_sequencer;

    localparam int WT_W = 12;
    localparam int B_W  = 7;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [B_W:0]     cfg_co   = '0;
    logic [9:0]       cfg_ci   = '0;
    logic [WT_W-1:0]  cfg_base = '0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             busy, layer_done, err_cfg, aborted;
    logic [B_W-1:0]   group_idx;

    logic ready      = 1'b0;
    logic force_busy = 1'b0;
    logic man_done   = 1'b0;
    logic c_busy_m   = 1'b0;
    logic c_auto_done = 1'b0;
    int   lat  = 20;
    int   ccnt = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   cyc = 0;

    int n_tests = 0;
    int n_fail  = 0;

    conv_layer_sequencer_if #(.WT_ADDR_WIDTH(WT_W), .BIAS_ADDR_WIDTH(B_W)) ifc ();

    assign ifc.stream_ready = ready;
    assign ifc.conv_busy    = c_busy_m | force_busy;
    assign ifc.conv_done    = c_auto_done | man_done;

    conv_layer_sequencer #(.WT_ADDR_WIDTH(WT_W), .BIAS_ADDR_WIDTH(B_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_co_groups    (cfg_co),
        .cfg_ci_groups    (cfg_ci),
        .cfg_wt_layer_base(cfg_base),
        .start            (start),
        .abort            (abort),
        .busy             (busy),
        .layer_done       (layer_done),
        .err_cfg          (err_cfg),
        .aborted          (aborted),
        .group_idx        (group_idx),
        .ctrl             (ifc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, longint act, longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Controller model: done pulses `lat` cycles after go; lat==0 means done is driven by hand.
    initial begin
        forever begin
            @(posedge clk); #1;
            c_auto_done = 1'b0;
            if (ifc.conv_go && lat > 0) begin
                ccnt = lat;
                c_busy_m = 1'b1;
            end else if (ccnt > 0) begin
                ccnt--;
                if (ccnt == 0) begin
                    c_auto_done = 1'b1;
                    done_cyc = cyc;
                    done_cnt++;
                end
            end else begin
                c_busy_m = 1'b0;
            end
        end
    end

    // Reference model: a layer is a list of groups with addr = base + g*ci.
    bit m_busy, m_launched;
    int m_group, m_addr, m_ci, m_co, m_due, m_from;
    bit e_busy, e_done, e_err, e_abt, e_restart, e_go;
    int e_group, e_addr, e_ci;

    task automatic model_clear();
        m_busy = 0; m_launched = 0; m_group = 0; m_addr = 0; m_ci = 0; m_co = 0;
        m_due = -1; m_from = 0;
        e_busy = 0; e_done = 0; e_err = 0; e_abt = 0; e_restart = 0; e_go = 0;
        e_group = 0; e_addr = 0; e_ci = 0;
    endtask

    task automatic schedule_group(int c);
        m_due = c + 2;
        m_from = c + 3;
        m_launched = 0;
    endtask

    task automatic model_step();
        int c;
        int sum;
        c = cyc;
        e_done = 0; e_err = 0; e_abt = 0; e_restart = 0; e_go = 0;
        if (!m_busy) begin
            if (start && !abort) begin
                if (cfg_co == 0 || cfg_ci == 0) begin
                    e_err = 1;
                end else begin
                    m_busy = 1; m_co = int'(cfg_co); m_ci = int'(cfg_ci);
                    m_group = 0; m_addr = int'(cfg_base);
                    schedule_group(c);
                end
            end
        end else if (abort) begin
            m_busy = 0;
            e_abt = 1;
        end else begin
            if (c + 1 == m_due) begin
                e_restart = 1; e_group = m_group; e_addr = m_addr; e_ci = m_ci;
            end
            if (!m_launched) begin
                if (c >= m_from && ready && !ifc.conv_busy) begin
                    e_go = 1;
                    m_launched = 1;
                end
            end else if (ifc.conv_done) begin
                if (m_group == m_co - 1) begin
                    m_busy = 0;
                    e_done = 1;
                end else begin
                    sum = m_addr + m_ci;
                    if (sum >= (1 << WT_W)) begin
                        m_busy = 0;
                        e_err = 1;
                    end else begin
                        m_group++;
                        m_addr = sum;
                        schedule_group(c);
                    end
                end
            end
        end
        e_busy = m_busy;
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_clear();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("cmp_busy", busy, e_busy);
                check("cmp_layer_done", layer_done, e_done);
                check("cmp_err_cfg", err_cfg, e_err);
                check("cmp_aborted", aborted, e_abt);
                check("cmp_stream_restart", ifc.stream_restart, e_restart);
                check("cmp_conv_go", ifc.conv_go, e_go);
                check("cmp_group_idx", group_idx, e_group);
                check("cmp_conv_output_group", ifc.conv_output_group, e_group);
                check("cmp_conv_wt_base_addr", ifc.conv_wt_base_addr, e_addr);
                check("cmp_conv_ci_groups", ifc.conv_ci_groups, e_ci);
            end
        end
    end

    // Event log for the directed literal checks.
    int n_go = 0, n_restart = 0, n_ldone = 0, n_err = 0, n_abt = 0, n_busy_cyc = 0;
    int ldone_cyc = 0, err_cyc = 0, abt_cyc = 0;
    int go_addr[$];
    int go_grp[$];
    int go_cyc[$];

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ifc.conv_go) begin
                    go_addr.push_back(int'(ifc.conv_wt_base_addr));
                    go_grp.push_back(int'(ifc.conv_output_group));
                    go_cyc.push_back(cyc);
                    n_go++;
                end
                if (ifc.stream_restart) n_restart++;
                if (layer_done) begin n_ldone++; ldone_cyc = cyc; end
                if (err_cfg) begin n_err++; err_cyc = cyc; end
                if (aborted) begin n_abt++; abt_cyc = cyc; end
                if (busy) n_busy_cyc++;
            end
        end
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    function automatic int cnt_of(int kind);
        case (kind)
            0: return n_go;
            1: return n_restart;
            2: return n_ldone;
            3: return n_err;
            4: return done_cnt;
            default: return 0;
        endcase
    endfunction

    task automatic wait_for(int kind, int target, int budget, string name);
        int b;
        b = budget;
        while (cnt_of(kind) < target && b > 0) begin
            step();
            b--;
        end
        check(name, cnt_of(kind), target);
    endtask

    task automatic run_three_group(string tag);
        int b_go, b_rs, b_ld, t;
        int exp_addr[3];
        exp_addr = '{'h100, 'h104, 'h108};
        b_go = n_go; b_rs = n_restart; b_ld = n_ldone;
        ready = 1; force_busy = 0; lat = 20;
        cfg_co = 3; cfg_ci = 4; cfg_base = 'h100;
        start = 1; t = cyc; step(); start = 0;
        wait_for(2, b_ld + 1, 300, {tag, "_ldone_wait"});
        step(); step();
        check({tag, "_go_count"}, n_go - b_go, 3);
        if (n_go - b_go >= 3) begin
            for (int i = 0; i < 3; i++) begin
                check({tag, "_go_addr"}, go_addr[b_go + i], exp_addr[i]);
                check({tag, "_go_group"}, go_grp[b_go + i], i);
            end
            check({tag, "_first_go_cycle"}, go_cyc[b_go], t + 4);
        end
        check({tag, "_restart_count"}, n_restart - b_rs, 3);
        check({tag, "_ldone_count"}, n_ldone - b_ld, 1);
        check({tag, "_ldone_latency"}, ldone_cyc - done_cyc, 1);
        repeat (3) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_go, b_rs, b_ld, b_err, b_abt, b_busy, b_d, t, r;

        repeat (3) step();
        rst = 0;
        step();
        check("reset_busy", busy, 0);
        check("reset_conv_go", ifc.conv_go, 0);
        check("reset_wt_addr", ifc.conv_wt_base_addr, 0);
        check("reset_group_idx", group_idx, 0);

        run_three_group("three");

        // Invalid configurations: co==0, then ci==0.
        for (int k = 0; k < 2; k++) begin
            b_err = n_err; b_go = n_go; b_busy = n_busy_cyc;
            cfg_co = (k == 0) ? 0 : 3;
            cfg_ci = (k == 0) ? 4 : 0;
            start = 1; t = cyc; step(); start = 0;
            repeat (6) step();
            check("badcfg_err_count", n_err - b_err, 1);
            check("badcfg_err_cycle", err_cyc, t + 1);
            check("badcfg_busy_cycles", n_busy_cyc - b_busy, 0);
            check("badcfg_go_count", n_go - b_go, 0);
        end

        // Weight address wrap: 0xF00 + 0x200 overflows 12 bits.
        b_go = n_go; b_err = n_err; b_ld = n_ldone; b_rs = n_restart;
        lat = 5; ready = 1;
        cfg_co = 2; cfg_ci = 'h200; cfg_base = 'hF00;
        start = 1; step(); start = 0;
        wait_for(3, b_err + 1, 100, "wrap_err_wait");
        repeat (10) step();
        check("wrap_go_count", n_go - b_go, 1);
        if (n_go - b_go >= 1) check("wrap_go_addr", go_addr[b_go], 'hF00);
        check("wrap_err_latency", err_cyc - done_cyc, 1);
        check("wrap_ldone_count", n_ldone - b_ld, 0);
        check("wrap_restart_count", n_restart - b_rs, 1);

        // Back-pressure from the pixel source.
        b_go = n_go; b_rs = n_restart; b_ld = n_ldone;
        ready = 0; lat = 3;
        cfg_co = 1; cfg_ci = 1; cfg_base = 'h20;
        start = 1; step(); start = 0;
        wait_for(1, b_rs + 1, 20, "bp_restart_wait");
        repeat (9) step();
        check("bp_no_go_while_not_ready", n_go - b_go, 0);
        ready = 1; r = cyc;
        wait_for(0, b_go + 1, 20, "bp_go_wait");
        if (n_go - b_go >= 1) begin
            check("bp_go_cycle", go_cyc[b_go], r + 1);
            check("bp_go_addr", go_addr[b_go], 'h20);
        end
        wait_for(2, b_ld + 1, 50, "bp_ldone_wait");
        repeat (3) step();

        // Back-pressure from a busy controller.
        b_go = n_go; b_ld = n_ldone;
        force_busy = 1; ready = 1;
        cfg_co = 1; cfg_ci = 1; cfg_base = 'h30;
        start = 1; step(); start = 0;
        repeat (13) step();
        check("cbusy_no_go", n_go - b_go, 0);
        force_busy = 0; r = cyc;
        wait_for(0, b_go + 1, 20, "cbusy_go_wait");
        if (n_go - b_go >= 1) check("cbusy_go_cycle", go_cyc[b_go], r + 1);
        wait_for(2, b_ld + 1, 50, "cbusy_ldone_wait");
        repeat (3) step();

        // Abort while group 1 of 4 is running; its later done must be ignored.
        b_go = n_go; b_rs = n_restart; b_ld = n_ldone; b_abt = n_abt; b_err = n_err;
        lat = 30;
        cfg_co = 4; cfg_ci = 1; cfg_base = 0;
        start = 1; step(); start = 0;
        wait_for(0, b_go + 2, 200, "abort_go_wait");
        repeat (4) step();
        abort = 1; t = cyc; step(); abort = 0;
        check("abort_busy_low", busy, 0);
        repeat (40) step();
        check("abort_count", n_abt - b_abt, 1);
        check("abort_cycle", abt_cyc, t + 1);
        check("abort_go_count", n_go - b_go, 2);
        check("abort_restart_count", n_restart - b_rs, 2);
        check("abort_ldone_count", n_ldone - b_ld, 0);
        check("abort_err_count", n_err - b_err, 0);

        // Abort in the same cycle as done: no further SETUP.
        b_go = n_go; b_rs = n_restart; b_abt = n_abt; b_ld = n_ldone;
        lat = 0;
        cfg_co = 3; cfg_ci = 1; cfg_base = 0;
        start = 1; step(); start = 0;
        wait_for(0, b_go + 1, 20, "abdone_go_wait");
        repeat (3) step();
        man_done = 1; abort = 1; step(); man_done = 0; abort = 0;
        repeat (8) step();
        check("abdone_restart_count", n_restart - b_rs, 1);
        check("abdone_go_count", n_go - b_go, 1);
        check("abdone_abort_count", n_abt - b_abt, 1);
        check("abdone_ldone_count", n_ldone - b_ld, 0);

        // Asynchronous reset during the SETUP cycle of group 1.
        lat = 20; ready = 1;
        cfg_co = 3; cfg_ci = 4; cfg_base = 'h100;
        b_d = done_cnt;
        start = 1; step(); start = 0;
        wait_for(4, b_d + 1, 100, "rst_done_wait");
        step();
        check("rst_pre_busy", busy, 1);
        check("rst_pre_wt_addr", ifc.conv_wt_base_addr, 'h100);
        #1 rst = 1;
        #1;
        check("rst_async_busy", busy, 0);
        check("rst_async_wt_addr", ifc.conv_wt_base_addr, 0);
        check("rst_async_ci", ifc.conv_ci_groups, 0);
        check("rst_async_group", ifc.conv_output_group, 0);
        check("rst_async_restart", ifc.stream_restart, 0);
        check("rst_async_go", ifc.conv_go, 0);
        step(); step();
        rst = 0;
        step();
        run_three_group("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
